// File: rtl/port_uart_pkg.sv
// Shared constants and types for the port-mapped UART.
// Register offsets, STATUS bit indices, FSM state types and a sticky-flag helper.
package port_uart_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [1:0] PORT_UART_DATA   = 2'd0;
  localparam logic [1:0] PORT_UART_STATUS = 2'd1;
  localparam logic [1:0] PORT_UART_DIV    = 2'd2;

  // STATUS bit indices
  localparam int unsigned STAT_RX_NONEMPTY = 0;
  localparam int unsigned STAT_TX_NOTFULL  = 1;
  localparam int unsigned STAT_TX_IDLE     = 2;
  localparam int unsigned STAT_RX_OVF      = 3;
  localparam int unsigned STAT_TX_OVF      = 4;
  localparam int unsigned STAT_FRAME_ERR   = 5;
  localparam int unsigned STAT_LOOPBACK    = 6;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // A set event in the same cycle as a W1C clear wins.
  function automatic logic sticky_next(input logic q, input logic set, input logic clr);
    return (q & ~clr) | set;
  endfunction

endpackage

// File: rtl/port_uart_if.sv
// CPU IN/OUT port bus: address, write data, read/write strobes and registered read data.
interface port_uart_if;
  logic [15:0] portaddr;
  logic [15:0] portval;
  logic        portget;
  logic        portset;
  logic [15:0] portout;

  modport master (output portaddr, output portval, output portget, output portset,
                  input portout);
  modport slave  (input portaddr, input portval, input portget, input portset,
                  output portout);
endinterface

// File: rtl/port_uart_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; head byte is visible on dout_o without a pop.
// A push while full is accepted only when a pop happens in the same cycle.
module port_uart_byte_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0] wr_ptr_q, wr_ptr_d;
  logic [Aw:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [Depth];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q[Aw-1:0]];

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= din_i;
  end

endmodule

// File: rtl/port_uart.sv
// Port-mapped UART: DATA/STATUS/DIVISOR registers on the CPU port bus, TX and RX byte FIFOs,
// 8N1 framing with a programmable bit time of DIVISOR+1 clocks.
// Optional feature: define UART_PORT_LOOPBACK_EN for STATUS b6 internal loopback.
module port_uart
  import port_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0010,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  port_uart_if.slave    bus,
  input  logic          rxd_i,
  output logic          txd_o
);

  // Bus decode
  logic [15:0] offset;
  logic        in_win, wr_data, wr_status, wr_div, rd_data;

  assign offset    = bus.portaddr - BASE_ADDR;
  assign in_win    = (offset[15:2] == 14'd0);
  assign wr_data   = bus.portset && in_win && (offset[1:0] == PORT_UART_DATA);
  assign wr_status = bus.portset && in_win && (offset[1:0] == PORT_UART_STATUS);
  assign wr_div    = bus.portset && in_win && (offset[1:0] == PORT_UART_DIV);
  assign rd_data   = bus.portget && in_win && (offset[1:0] == PORT_UART_DATA);

  // Registers
  logic [15:0] portout_q, portout_d;
  logic [15:0] div_q, div_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        frame_err_q, frame_err_d;

  // FIFO signals
  logic       tx_full, tx_empty, tx_push, tx_fetch;
  logic [7:0] tx_dout;
  logic       rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0] rx_dout;

  // Serial state
  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        tx_line_q;

  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rxd_meta_q, rxd_sync_q, rx_prev_q;
  logic        rx_line;
  logic        rx_stop_sample, rx_done_ok, rx_done_bad;

`ifdef UART_PORT_LOOPBACK_EN
  logic loopback_q, loopback_d;
  // Internal TX line feeds RX directly; external line parks high
  assign rx_line = loopback_q ? tx_line_q : rxd_sync_q;
  assign txd_o   = loopback_q ? 1'b1 : tx_line_q;
`else
  assign rx_line = rxd_sync_q;
  assign txd_o   = tx_line_q;
`endif

  // FIFO control
  // The shifter fetches from IDLE, or from the end of STOP for back-to-back frames
  assign tx_fetch = !tx_empty &&
                    ((tx_state_q == TxIdle) || ((tx_state_q == TxStop) && (tx_cnt_q == '0)));
  assign tx_push  = wr_data && (!tx_full || tx_fetch);

  assign rx_stop_sample = (rx_state_q == RxStop) && (rx_cnt_q == '0);
  assign rx_done_ok     = rx_stop_sample && rx_line;
  assign rx_done_bad    = rx_stop_sample && !rx_line;
  assign rx_push        = rx_done_ok && !rx_full;
  assign rx_pop         = rd_data && !rx_empty;

  port_uart_byte_fifo #(.Depth(FIFO_DEPTH)) u_tx_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (tx_push),
    .pop_i    (tx_fetch),
    .din_i    (bus.portval[7:0]),
    .dout_o   (tx_dout),
    .full_o   (tx_full),
    .empty_o  (tx_empty)
  );

  port_uart_byte_fifo #(.Depth(FIFO_DEPTH)) u_rx_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (rx_push),
    .pop_i    (rx_pop),
    .din_i    (rx_sh_q),
    .dout_o   (rx_dout),
    .full_o   (rx_full),
    .empty_o  (rx_empty)
  );

  // STATUS word assembled from live FIFO/FSM state and sticky flags
  logic [15:0] status;
  always_comb begin
    status                   = 16'h0000;
    status[STAT_RX_NONEMPTY] = !rx_empty;
    status[STAT_TX_NOTFULL]  = !tx_full;
    status[STAT_TX_IDLE]     = tx_empty && (tx_state_q == TxIdle);
    status[STAT_RX_OVF]      = rx_ovf_q;
    status[STAT_TX_OVF]      = tx_ovf_q;
    status[STAT_FRAME_ERR]   = frame_err_q;
`ifdef UART_PORT_LOOPBACK_EN
    status[STAT_LOOPBACK]    = loopback_q;
`endif
  end

  // Read mux; always reflects pre-write register values
  logic [15:0] rd_val;
  always_comb begin
    rd_val = 16'h0000;
    case (offset[1:0])
      PORT_UART_DATA:   rd_val = {8'h00, rx_empty ? 8'h00 : rx_dout};
      PORT_UART_STATUS: rd_val = status;
      PORT_UART_DIV:    rd_val = div_q;
      default:          rd_val = 16'h0000;
    endcase
  end

  // Register-file next state: read data, divisor, sticky flags with W1C
  logic [15:0] w1c;
  always_comb begin
    portout_d = portout_q;
    if (bus.portget) portout_d = in_win ? rd_val : 16'h0000;
    div_d       = wr_div ? bus.portval : div_q;
    w1c         = wr_status ? bus.portval : 16'h0000;
    rx_ovf_d    = sticky_next(rx_ovf_q, rx_done_ok && rx_full, w1c[STAT_RX_OVF]);
    tx_ovf_d    = sticky_next(tx_ovf_q, wr_data && tx_full && !tx_fetch, w1c[STAT_TX_OVF]);
    frame_err_d = sticky_next(frame_err_q, rx_done_bad, w1c[STAT_FRAME_ERR]);
`ifdef UART_PORT_LOOPBACK_EN
    loopback_d  = wr_status ? bus.portval[STAT_LOOPBACK] : loopback_q;
`endif
  end

  // Register-file state
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      portout_q   <= 16'h0000;
      div_q       <= DEFAULT_DIV;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PORT_LOOPBACK_EN
      loopback_q  <= 1'b0;
`endif
    end else begin
      portout_q   <= portout_d;
      div_q       <= div_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      frame_err_q <= frame_err_d;
`ifdef UART_PORT_LOOPBACK_EN
      loopback_q  <= loopback_d;
`endif
    end
  end

  assign bus.portout = portout_q;

  // TX FSM: START, 8 data bits LSB first, STOP; each lasts DIVISOR+1 clocks
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TxIdle: begin
          if (!tx_empty) begin
            tx_state_q <= TxStart;
            tx_sh_q    <= tx_dout;
            tx_cnt_q   <= div_q;
            tx_line_q  <= 1'b0;
          end
        end
        TxStart: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= TxData;
            tx_line_q  <= tx_sh_q[0];
            tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
            tx_bit_q   <= '0;
            tx_cnt_q   <= div_q;
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        TxData: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= div_q;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TxStop;
              tx_line_q  <= 1'b1;
            end else begin
              tx_line_q <= tx_sh_q[0];
              tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q  <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        TxStop: begin
          if (tx_cnt_q == '0) begin
            if (!tx_empty) begin
              tx_state_q <= TxStart;
              tx_sh_q    <= tx_dout;
              tx_cnt_q   <= div_q;
              tx_line_q  <= 1'b0;
            end else begin
              tx_state_q <= TxIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // rxd synchroniser and edge-detect history; idles high
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rx_prev_q  <= rx_line;
    end
  end

  // RX FSM: half-bit start check, then full-bit spaced samples for data and stop
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_line) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= {1'b0, div_q[15:1]};
          end
        end
        RxStart: begin
          if (rx_cnt_q == '0) begin
            if (!rx_line) begin
              rx_state_q <= RxData;
              rx_bit_q   <= '0;
              rx_cnt_q   <= div_q;
            end else begin
              rx_state_q <= RxIdle;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt_q == '0) begin
            rx_sh_q  <= {rx_line, rx_sh_q[7:1]};
            rx_cnt_q <= div_q;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RxStop: begin
          // Push / frame-error decisions are taken combinationally on this sample
          if (rx_cnt_q == '0) rx_state_q <= RxIdle;
          else                rx_cnt_q   <= rx_cnt_q - 1'b1;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_port_uart.sv
// Self-checking bench for port_uart: register access, TX/RX framing, FIFO limits, loopback.
module tb_port_uart;

  localparam logic [15:0] A_DATA = 16'h0010;
  localparam logic [15:0] A_STAT = 16'h0011;
  localparam logic [15:0] A_DIV  = 16'h0012;
  localparam logic [15:0] A_RSVD = 16'h0013;
  localparam int          DEPTH  = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic rxd;
  logic txd;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  port_uart_if bus_if ();

  port_uart #(
    .BASE_ADDR   (16'h0010),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus_if),
    .rxd_i    (rxd),
    .txd_o    (txd)
  );

  // Bus tasks are entered on a falling edge and return on the next one
  task automatic io_write(input logic [15:0] a, input logic [15:0] v);
    bus_if.portaddr = a;
    bus_if.portval  = v;
    bus_if.portset  = 1'b1;
    @(negedge clk);
    bus_if.portset  = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] a, output logic [15:0] v);
    bus_if.portaddr = a;
    bus_if.portget  = 1'b1;
    @(negedge clk);
    bus_if.portget  = 1'b0;
    v = bus_if.portout;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  // Expected STATUS from model flags
  function automatic logic [15:0] stat_word(input logic rxne, input logic txnf, input logic txid,
                                            input logic rxo, input logic txo, input logic fe,
                                            input logic lb);
    return {9'd0, lb, fe, txo, rxo, txid, txnf, rxne};
  endfunction

  // Compare txd against the ideal 8N1 waveform: 10 bits of (div+1) clocks each
  task automatic check_tx_frame(input logic [7:0] b, input int div, input string tag);
    logic [9:0] bits;
    logic       ok;
    logic       got;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ok  = 1'b1;
      got = bits[i];
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        if (txd !== bits[i]) begin
          ok  = 1'b0;
          got = txd;
        end
      end
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s byte %h bit %0d: txd=%b expected %b", tag, b, i, got, bits[i]);
      end
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit, input int div);
    rxd = 1'b0;
    idle(div + 1);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(div + 1);
    end
    rxd = stop_bit;
    idle(div + 1);
    rxd = 1'b1;
  endtask

  task automatic expect16(input logic [15:0] got, input logic [15:0] exp, input string tag);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    expect16(bus_if.portout, 16'h0000, "reset portout");
    expect16({15'd0, txd}, 16'h0001, "reset txd");
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "reset STATUS");
    io_read(A_DIV, v);
    expect16(v, 16'd433, "reset DIVISOR");
  endtask

  task automatic test_window();
    logic [15:0] v;
    io_write(A_RSVD, 16'hBEEF);
    io_read(A_RSVD, v);
    expect16(v, 16'h0000, "reserved offset 3");
    io_read(A_DIV, v);
    io_read(16'h0014, v);
    expect16(v, 16'h0000, "read above window");
    io_read(A_DIV, v);
    io_read(16'h000F, v);
    expect16(v, 16'h0000, "read below window");
  endtask

  task automatic test_simul_rw();
    logic [15:0] v, d1, d2;
    d1 = 16'($urandom);
    d2 = ~d1;
    io_write(A_DIV, d1);
    bus_if.portaddr = A_DIV;
    bus_if.portval  = d2;
    bus_if.portget  = 1'b1;
    bus_if.portset  = 1'b1;
    @(negedge clk);
    bus_if.portget  = 1'b0;
    bus_if.portset  = 1'b0;
    expect16(bus_if.portout, d1, "simultaneous get/set returns old DIV");
    io_read(A_DIV, v);
    expect16(v, d2, "simultaneous get/set wrote new DIV");
    idle(3);
    expect16(bus_if.portout, d2, "portout holds without portget");
  endtask

  task automatic test_tx_frame();
    logic [15:0] v;
    int          div;
    logic [7:0]  b;
    for (int k = 0; k < 4; k++) begin
      div = (k == 0) ? 3 : int'($urandom_range(2, 6));
      b   = (k == 0) ? 8'hA5 : 8'($urandom);
      io_write(A_DIV, 16'(div));
      io_write(A_DATA, {8'h00, b});
      // One cycle after the write the line must still be idle
      expect16({15'd0, txd}, 16'h0001, "tx latency idle cycle");
      check_tx_frame(b, div, "tx frame");
      idle(2);
      io_read(A_STAT, v);
      expect16(v, 16'h0006, "tx idle after frame");
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [7:0]  b [3];
    int          div;
    div = int'($urandom_range(2, 5));
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    io_write(A_DIV, 16'(div));
    io_write(A_DATA, {8'h00, b[0]});
    fork
      begin
        for (int i = 0; i < 3; i++) check_tx_frame(b[i], div, "back-to-back");
      end
      begin
        io_write(A_DATA, {8'h00, b[1]});
        io_write(A_DATA, {8'h00, b[2]});
      end
    join
    idle(2);
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "tx idle after back-to-back");
  endtask

  task automatic test_rx_frame();
    logic [15:0] v;
    logic [7:0]  b;
    int          div;
    for (int k = 0; k < 4; k++) begin
      div = (k == 0) ? 3 : int'($urandom_range(2, 7));
      b   = (k == 0) ? 8'h3C : 8'($urandom);
      io_write(A_DIV, 16'(div));
      drive_rx_frame(b, 1'b1, div);
      idle(4);
      io_read(A_STAT, v);
      expect16(v, stat_word(1, 1, 1, 0, 0, 0, 0), "rx nonempty");
      io_read(A_DATA, v);
      expect16(v, {8'h00, b}, "rx data");
      io_read(A_DATA, v);
      expect16(v, 16'h0000, "rx empty read");
    end
  endtask

  task automatic test_rx_overflow();
    logic [15:0] v;
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic        ovf;
    ovf = 1'b0;
    io_write(A_DIV, 16'd3);
    for (int k = 0; k < DEPTH + 1; k++) begin
      b = 8'($urandom);
      drive_rx_frame(b, 1'b1, 3);
      idle(4);
      if (q.size() < DEPTH) q.push_back(b);
      else                  ovf = 1'b1;
    end
    io_read(A_STAT, v);
    expect16(v, stat_word(1, 1, 1, ovf, 0, 0, 0), "rx overflow status");
    while (q.size() > 0) begin
      io_read(A_DATA, v);
      expect16(v, {8'h00, q.pop_front()}, "rx fifo order");
    end
    io_read(A_DATA, v);
    expect16(v, 16'h0000, "rx drained");
    io_write(A_STAT, 16'h0008);
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "rx overflow W1C");
  endtask

  task automatic test_frame_err_glitch();
    logic [15:0] v;
    io_write(A_DIV, 16'd3);
    drive_rx_frame(8'($urandom), 1'b0, 3);
    idle(4);
    io_read(A_STAT, v);
    expect16(v, stat_word(0, 1, 1, 0, 0, 1, 0), "frame error status");
    io_read(A_DATA, v);
    expect16(v, 16'h0000, "frame error discards byte");
    io_write(A_STAT, 16'h0020);
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "frame error W1C");
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(50);
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "glitch ignored");
  endtask

  task automatic test_loopback();
    logic [15:0] v;
    logic        ok;
`ifdef UART_PORT_LOOPBACK_EN
    io_write(A_DIV, 16'd3);
    io_write(A_STAT, 16'h0040);
    io_read(A_STAT, v);
    expect16(v, 16'h0046, "loopback bit set");
    io_write(A_DATA, 16'h005A);
    ok = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
    end
    expect16({15'd0, ok}, 16'h0001, "loopback txd held high");
    io_read(A_DATA, v);
    expect16(v, 16'h005A, "loopback received byte");
    io_write(A_STAT, 16'h0000);
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "loopback bit cleared");
`else
    ok = 1'b1;
    io_write(A_STAT, 16'h0040);
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "loopback bit absent");
    expect16({15'd0, txd}, {15'd0, ok}, "txd idle without loopback");
`endif
  endtask

  task automatic test_tx_overflow_reset();
    logic [15:0] v;
    io_write(A_DIV, 16'hFFFF);
    // The first byte moves into the shifter, so nine writes exactly fill the FIFO
    for (int k = 0; k < DEPTH + 1; k++) io_write(A_DATA, 16'($urandom));
    io_read(A_STAT, v);
    expect16(v, stat_word(0, 0, 0, 0, 0, 0, 0), "tx full no overflow");
    io_write(A_DATA, 16'($urandom));
    io_read(A_STAT, v);
    expect16(v, stat_word(0, 0, 0, 0, 1, 0, 0), "tx overflow");
    io_write(A_STAT, 16'h0010);
    io_read(A_STAT, v);
    expect16(v, 16'h0000, "tx overflow W1C");
    expect16({15'd0, txd}, 16'h0000, "mid-frame start bit");
    reset_n = 1'b0;
    @(negedge clk);
    expect16({15'd0, txd}, 16'h0001, "reset abandons frame");
    @(negedge clk);
    reset_n = 1'b1;
    io_read(A_STAT, v);
    expect16(v, 16'h0006, "status after mid-frame reset");
    io_read(A_DIV, v);
    expect16(v, 16'd433, "divisor after mid-frame reset");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    rxd             = 1'b1;
    bus_if.portaddr = 16'h0000;
    bus_if.portval  = 16'h0000;
    bus_if.portget  = 1'b0;
    bus_if.portset  = 1'b0;
    @(negedge clk);
    test_reset();
    test_window();
    test_simul_rw();
    test_tx_frame();
    test_back_to_back();
    test_rx_frame();
    test_rx_overflow();
    test_frame_err_glitch();
    test_loopback();
    test_tx_overflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
